ddr4_v2_2_20_comparator_sel_pipe: RTL and testbench
===================================================

Name: ddr4_v2_2_20_comparator_sel_pipe

Overview:
Pipelined, multi-value successor to the single-value select comparator used in the AXI upsizer. Each accepted beat selects operand A or B and compares it against C_NUM_VALUES static constants. The compare chain is gated by the incoming carry, CIN. Results are delivered through a valid/ready elastic pipeline with programmable depth, so wide compares close timing in the upsizer command and wrap-detect paths.

Parameters:
C_FAMILY, "virtex6", FPGA family passed through to the carry_and instances.
C_DATA_WIDTH, 4, operand width in bits, 1..64.
C_NUM_VALUES, 2, number of static constants compared in parallel, 1..8.
C_VALUES, all zeros, packed constants, C_NUM_VALUES*C_DATA_WIDTH bits; value i occupies [i*C_DATA_WIDTH +: C_DATA_WIDTH].
C_PIPE_STAGES, 1, register stages between input and output, 0..3.

Ports:
ACLK  input  1  clock.
ARESET  input  1  reset; one clock; reset is asynchronous and active-high.
S_VALID  input  1  input beat valid.
S_READY  output  1  input beat accepted when S_VALID & S_READY.
S_CIN  input  1  carry-in; 0 forces all hits to 0.
S_SEL  input  1  0 compares S_A, 1 compares S_B.
S_A  input  C_DATA_WIDTH  operand A.
S_B  input  C_DATA_WIDTH  operand B.
M_VALID  output  1  result valid.
M_READY  input  1  downstream accept.
M_HIT  output  C_NUM_VALUES  bit i = CIN & (selected operand == value i).
M_ANY_HIT  output  1  OR of M_HIT.
M_HIT_IDX  output  max(1,clog2(C_NUM_VALUES))  lowest-numbered set bit of M_HIT; 0 when none is set.
HIT_CNT  output  16  saturating count of delivered beats with M_ANY_HIT=1 (optional feature).

Behaviour:
- Width padding: operands and values are zero-padded on the LSB side to a multiple of 2 bits, which is the LUT slice width. Pad slices always compare equal.
- Per value: the slice-equality vector is computed from the muxed operand. The slices are AND-reduced through the ddr4_v2_2_20_carry_and chain, seeded with S_CIN.
- Stage placement:
  - Stage 1 registers the slice-match vectors and CIN.
  - Stage 2 registers the reduced hits.
  - Stage 3 registers M_HIT_IDX and M_ANY_HIT.
  - The final outputs derive combinationally from the last stage.
- C_PIPE_STAGES=0: fully combinational; M_VALID=S_VALID, S_READY=M_READY, latency 0.
- C_PIPE_STAGES=N>0:
  - Each stage holds a valid bit plus payload.
  - A stage loads when it is empty or its successor is loading/consumed.
  - S_READY = first stage empty | first stage advancing (no combinational path from M_READY when the stage is empty).
  - Latency is N cycles with M_READY held 1.
  - Throughput is 1 beat/cycle.
  - No beat is dropped or duplicated.
- Hold rule: while M_VALID=1 and M_READY=0, M_HIT, M_ANY_HIT and M_HIT_IDX are stable and M_VALID stays 1.
- Back-pressure: upstream stages fill in order. S_READY drops only when all N stages hold data and M_READY=0.
- Simultaneous accept and deliver on the same cycle is allowed at full occupancy; occupancy is unchanged.
- Reset, whenever asserted, including mid-transfer:
  - All stage valids clear immediately, so M_VALID=0.
  - M_HIT=0, M_ANY_HIT=0, M_HIT_IDX=0, HIT_CNT=0.
  - S_READY=0 while ARESET=1; it becomes 1 on the first ACLK edge after deassertion.
  - In-flight beats are discarded.
- Duplicate constants: all matching bits are set, and M_HIT_IDX reports the lowest index.
- S_CIN=0: M_HIT=0 regardless of operands; the beat is still delivered.

Optional Feature:
COMPARATOR_SEL_PIPE_HIT_CNT_EN
- Defined: HIT_CNT increments on each M_VALID & M_READY & M_ANY_HIT. It saturates at 16'hFFFF and clears only on ARESET.
- Undefined: HIT_CNT is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package ddr4_v2_2_20_axi_cmp_pkg holds:
  - localparam C_BITS_PER_LUT=2;
  - function clog2;
  - function lowest_set_idx;
  - slice-count helper function.
- Sub-module ddr4_v2_2_20_comparator_pipe_stage: one elastic register slice (valid/ready, parametrised payload width), instantiated C_PIPE_STAGES times via generate.
- Existing ddr4_v2_2_20_carry_and is reused for the reduction chains.

Test Plan:
Common configuration: C_DATA_WIDTH=5, C_NUM_VALUES=2, C_VALUES={5'h03,5'h1A}, i.e. value0=5'h1A and value1=5'h03.
1. Pipe=2, S_SEL=0, S_A=5'h1A, CIN=1, M_READY=1 -> after 2 cycles M_HIT=2'b01, M_ANY_HIT=1, M_HIT_IDX=0.
2. Pipe=2, S_SEL=1, S_A=5'h1A, S_B=5'h03, CIN=1 -> M_HIT=2'b10, M_HIT_IDX=1. The same beat with CIN=0 -> M_HIT=0, M_ANY_HIT=0, M_VALID=1.
3. Pipe=3, stream 6 back-to-back beats, M_READY=0 for cycles 2..6 -> S_READY falls after 3 beats are held; outputs are stable while stalled; all 6 results arrive in order once M_READY=1.
4. Pipe=1, ARESET pulsed for 1 cycle while M_VALID=1 and two beats are pending -> M_VALID=0 immediately, HIT_CNT=0, S_READY=1 one edge after release, no stale beat emitted.
5. Pipe=0, toggle S_A between 5'h1A and 5'h00 each cycle with M_READY toggling -> M_HIT follows same-cycle; S_READY==M_READY.
6. With COMPARATOR_SEL_PIPE_HIT_CNT_EN: 70000 hit beats -> HIT_CNT=16'hFFFF. Without the macro -> HIT_CNT=0 throughout.

Source files
------------

// File: rtl/ddr4_v2_2_20_axi_cmp_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined select comparator.
package ddr4_v2_2_20_axi_cmp_pkg;

  localparam int C_BITS_PER_LUT = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // Index port is never narrower than one bit, even for a single constant.
  function automatic int idx_width(input int num_values);
    return (clog2(num_values) > 1) ? clog2(num_values) : 1;
  endfunction

  function automatic int num_slices(input int width);
    return (width + C_BITS_PER_LUT - 1) / C_BITS_PER_LUT;
  endfunction

  function automatic int lowest_set_idx(input logic [7:0] vec);
    int idx;
    idx = 0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ddr4_v2_2_20_carry_and.sv
// One link of a carry-chain AND: COUT = CIN & S, mux form on FPGA families.
module ddr4_v2_2_20_carry_and #(
  parameter string C_FAMILY = "virtex6"
) (
  input  logic CIN,
  input  logic S,
  output logic COUT
);

  if (C_FAMILY == "rtl") begin : g_rtl
    assign COUT = CIN & S;
  end else begin : g_fpga
    // Mirrors the MUXCY select: pass the carry when the slice matches.
    assign COUT = S ? CIN : 1'b0;
  end

endmodule

// File: rtl/ddr4_v2_2_20_comparator_pipe_stage.sv
// Single elastic register slice: valid bit plus payload, full throughput.
module ddr4_v2_2_20_comparator_pipe_stage #(
  parameter int C_WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [C_WIDTH-1:0] up_data,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [C_WIDTH-1:0] dn_data
);

  logic               valid_reg;
  logic [C_WIDTH-1:0] data_reg;

  // Payload only moves when empty or being consumed, so a stalled output holds.
  assign up_ready = ~valid_reg | dn_ready;
  assign dn_valid = valid_reg;
  assign dn_data  = data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (up_ready) begin
      valid_reg <= up_valid;
      if (up_valid) data_reg <= up_data;
    end
  end

endmodule

// File: rtl/ddr4_v2_2_20_comparator_sel_pipe.sv
// Pipelined multi-value select comparator with 0..3 elastic stages.
// Optional macro COMPARATOR_SEL_PIPE_HIT_CNT_EN enables the saturating HIT_CNT counter.
module ddr4_v2_2_20_comparator_sel_pipe
  import ddr4_v2_2_20_axi_cmp_pkg::*;
#(
  parameter string                                C_FAMILY      = "virtex6",
  parameter int                                   C_DATA_WIDTH  = 4,
  parameter int                                   C_NUM_VALUES  = 2,
  parameter logic [C_NUM_VALUES*C_DATA_WIDTH-1:0] C_VALUES      = '0,
  parameter int                                   C_PIPE_STAGES = 1
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic                                  S_VALID,
  output logic                                  S_READY,
  input  logic                                  S_CIN,
  input  logic                                  S_SEL,
  input  logic [C_DATA_WIDTH-1:0]               S_A,
  input  logic [C_DATA_WIDTH-1:0]               S_B,
  output logic                                  M_VALID,
  input  logic                                  M_READY,
  output logic [C_NUM_VALUES-1:0]               M_HIT,
  output logic                                  M_ANY_HIT,
  output logic [idx_width(C_NUM_VALUES)-1:0]    M_HIT_IDX,
  output logic [15:0]                           HIT_CNT
);

  localparam int NS  = num_slices(C_DATA_WIDTH);
  localparam int PW  = NS * C_BITS_PER_LUT;
  localparam int PAD = PW - C_DATA_WIDTH;
  localparam int NM  = C_NUM_VALUES * NS;
  localparam int IW  = idx_width(C_NUM_VALUES);
  localparam int N   = C_PIPE_STAGES;

  // Holds S_READY low during reset and until the first edge after release.
  logic rst_done_reg;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rst_done_reg <= 1'b0;
    else        rst_done_reg <= 1'b1;
  end

  logic [C_DATA_WIDTH-1:0] sel_op;
  logic [PW-1:0]           op_pad;
  logic [NM-1:0]           match_comb;

  assign sel_op = S_SEL ? S_B : S_A;
  assign op_pad = PW'(sel_op) << PAD;

  for (genvar gi = 0; gi < C_NUM_VALUES; gi++) begin : g_val
    localparam logic [PW-1:0] VAL_PAD = PW'(C_VALUES[gi*C_DATA_WIDTH +: C_DATA_WIDTH]) << PAD;
    for (genvar gj = 0; gj < NS; gj++) begin : g_slice
      assign match_comb[gi*NS+gj] =
        (op_pad[gj*C_BITS_PER_LUT +: C_BITS_PER_LUT] == VAL_PAD[gj*C_BITS_PER_LUT +: C_BITS_PER_LUT]);
    end
  end

  // hs_*[k] is the handshake into stage k+1; hs_*[N] is the output port.
  logic [N:0] hs_valid;
  logic [N:0] hs_ready;

  assign hs_valid[0] = S_VALID & rst_done_reg;
  assign S_READY     = hs_ready[0] & rst_done_reg;
  assign M_VALID     = hs_valid[N];
  assign hs_ready[N] = M_READY;

  logic [NM-1:0] red_match;
  logic          red_cin;

  if (N >= 1) begin : g_stage1
    logic [NM:0] s1_q;
    ddr4_v2_2_20_comparator_pipe_stage #(.C_WIDTH(NM + 1)) u_stage (
      .clk      (ACLK),
      .rst      (ARESET),
      .up_valid (hs_valid[0]),
      .up_ready (hs_ready[0]),
      .up_data  ({S_CIN, match_comb}),
      .dn_valid (hs_valid[1]),
      .dn_ready (hs_ready[1]),
      .dn_data  (s1_q)
    );
    assign red_match = s1_q[NM-1:0];
    assign red_cin   = s1_q[NM];
  end else begin : g_stage1_bypass
    assign red_match = match_comb;
    assign red_cin   = S_CIN & rst_done_reg;
  end

  logic [C_NUM_VALUES-1:0] red_hit;

  for (genvar gi = 0; gi < C_NUM_VALUES; gi++) begin : g_chain
    logic [NS:0] carry;
    assign carry[0] = red_cin;
    for (genvar gj = 0; gj < NS; gj++) begin : g_link
      ddr4_v2_2_20_carry_and #(.C_FAMILY(C_FAMILY)) u_and (
        .CIN  (carry[gj]),
        .S    (red_match[gi*NS+gj]),
        .COUT (carry[gj+1])
      );
    end
    assign red_hit[gi] = carry[NS];
  end

  logic [C_NUM_VALUES-1:0] hit_src;

  if (N >= 2) begin : g_stage2
    ddr4_v2_2_20_comparator_pipe_stage #(.C_WIDTH(C_NUM_VALUES)) u_stage (
      .clk      (ACLK),
      .rst      (ARESET),
      .up_valid (hs_valid[1]),
      .up_ready (hs_ready[1]),
      .up_data  (red_hit),
      .dn_valid (hs_valid[2]),
      .dn_ready (hs_ready[2]),
      .dn_data  (hit_src)
    );
  end else begin : g_stage2_bypass
    assign hit_src = red_hit;
  end

  logic          any_comb;
  logic [IW-1:0] idx_comb;

  assign any_comb = |hit_src;
  assign idx_comb = IW'(lowest_set_idx(8'(hit_src)));

  if (N >= 3) begin : g_stage3
    logic [C_NUM_VALUES+IW:0] s3_q;
    ddr4_v2_2_20_comparator_pipe_stage #(.C_WIDTH(C_NUM_VALUES + IW + 1)) u_stage (
      .clk      (ACLK),
      .rst      (ARESET),
      .up_valid (hs_valid[2]),
      .up_ready (hs_ready[2]),
      .up_data  ({hit_src, any_comb, idx_comb}),
      .dn_valid (hs_valid[3]),
      .dn_ready (hs_ready[3]),
      .dn_data  (s3_q)
    );
    assign M_HIT     = s3_q[C_NUM_VALUES+IW:IW+1];
    assign M_ANY_HIT = s3_q[IW];
    assign M_HIT_IDX = s3_q[IW-1:0];
  end else begin : g_stage3_bypass
    assign M_HIT     = hit_src;
    assign M_ANY_HIT = any_comb;
    assign M_HIT_IDX = idx_comb;
  end

`ifdef COMPARATOR_SEL_PIPE_HIT_CNT_EN
  logic [15:0] hit_cnt_reg;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      hit_cnt_reg <= '0;
    end else if (M_VALID && M_READY && M_ANY_HIT && (hit_cnt_reg != 16'hFFFF)) begin
      hit_cnt_reg <= hit_cnt_reg + 16'd1;
    end
  end
  assign HIT_CNT = hit_cnt_reg;
`else
  assign HIT_CNT = '0;
`endif

endmodule

// File: tb/tb_ddr4_v2_2_20_comparator_sel_pipe.sv
// Directed bench: one comparator instance per pipe depth 0..3, shared operands.
module tb_ddr4_v2_2_20_comparator_sel_pipe;

  logic       clk;
  logic       areset;
  logic       s_cin;
  logic       s_sel;
  logic [4:0] s_a;
  logic [4:0] s_b;
  logic       s_valid [4];
  logic       m_ready [4];
  logic       s_ready [4];
  logic       m_valid [4];
  logic [1:0] m_hit   [4];
  logic       m_any   [4];
  logic [0:0] m_idx   [4];
  logic [15:0] hit_cnt [4];

  int tests = 0;
  int fails = 0;
  int snt;
  int rcv;
  logic acc_in;

  // Stream table for the depth-3 stall test; value0=1A, value1=03.
  logic [4:0] t3_a   [6] = '{5'h1A, 5'h00, 5'h05, 5'h00, 5'h03, 5'h1A};
  logic [4:0] t3_b   [6] = '{5'h00, 5'h03, 5'h00, 5'h1A, 5'h00, 5'h00};
  logic       t3_sel [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       t3_cin [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int         t3_hit [6] = '{1, 2, 0, 1, 2, 0};
  int         t3_idx [6] = '{0, 1, 0, 0, 1, 0};

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    ddr4_v2_2_20_comparator_sel_pipe #(
      .C_FAMILY      ("virtex6"),
      .C_DATA_WIDTH  (5),
      .C_NUM_VALUES  (2),
      .C_VALUES      (10'h07A),
      .C_PIPE_STAGES (gi)
    ) u_dut (
      .ACLK      (clk),
      .ARESET    (areset),
      .S_VALID   (s_valid[gi]),
      .S_READY   (s_ready[gi]),
      .S_CIN     (s_cin),
      .S_SEL     (s_sel),
      .S_A       (s_a),
      .S_B       (s_b),
      .M_VALID   (m_valid[gi]),
      .M_READY   (m_ready[gi]),
      .M_HIT     (m_hit[gi]),
      .M_ANY_HIT (m_any[gi]),
      .M_HIT_IDX (m_idx[gi]),
      .HIT_CNT   (hit_cnt[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic sel, input logic [4:0] a,
                       input logic [4:0] b, input logic cin);
    s_valid[p] = 1'b1;
    s_sel = sel;
    s_a = a;
    s_b = b;
    s_cin = cin;
  endtask

  task automatic drive_t3(input int k);
    drive(3, t3_sel[k], t3_a[k], t3_b[k], t3_cin[k]);
  endtask

  initial begin
    areset = 1'b1;
    s_cin = 1'b0;
    s_sel = 1'b0;
    s_a = '0;
    s_b = '0;
    for (int p = 0; p < 4; p++) begin
      s_valid[p] = 1'b0;
      m_ready[p] = 1'b0;
    end

    // Reset state
    tick();
    for (int p = 0; p < 4; p++) begin
      check($sformatf("rst_m_valid%0d", p), 32'(m_valid[p]), 0);
      check($sformatf("rst_s_ready%0d", p), 32'(s_ready[p]), 0);
      check($sformatf("rst_m_hit%0d", p), 32'(m_hit[p]), 0);
      check($sformatf("rst_hit_cnt%0d", p), 32'(hit_cnt[p]), 0);
    end
    areset = 1'b0;
    tick();
    for (int p = 1; p < 4; p++) check($sformatf("rel_s_ready%0d", p), 32'(s_ready[p]), 1);

    // Test 1: depth 2, operand A hits value0
    m_ready[2] = 1'b1;
    drive(2, 1'b0, 5'h1A, 5'h00, 1'b1);
    #1 check("t1_s_ready", 32'(s_ready[2]), 1);
    tick();
    s_valid[2] = 1'b0;
    #1 check("t1_lat1_valid", 32'(m_valid[2]), 0);
    tick();
    check("t1_valid", 32'(m_valid[2]), 1);
    check("t1_hit", 32'(m_hit[2]), 32'h1);
    check("t1_any", 32'(m_any[2]), 1);
    check("t1_idx", 32'(m_idx[2]), 0);
    tick();
    check("t1_drained", 32'(m_valid[2]), 0);

    // Test 2: depth 2, operand B hits value1, then the same beat with CIN=0
    drive(2, 1'b1, 5'h1A, 5'h03, 1'b1);
    tick();
    drive(2, 1'b1, 5'h1A, 5'h03, 1'b0);
    tick();
    s_valid[2] = 1'b0;
    #1;
    check("t2_valid", 32'(m_valid[2]), 1);
    check("t2_hit", 32'(m_hit[2]), 32'h2);
    check("t2_idx", 32'(m_idx[2]), 1);
    tick();
    check("t2_cin0_valid", 32'(m_valid[2]), 1);
    check("t2_cin0_hit", 32'(m_hit[2]), 0);
    check("t2_cin0_any", 32'(m_any[2]), 0);
    check("t2_cin0_idx", 32'(m_idx[2]), 0);
    m_ready[2] = 1'b0;

    // Test 3: depth 3, six beats with the output stalled early on
    m_ready[3] = 1'b0;
    drive_t3(0);
    #1 check("t3_rdy0", 32'(s_ready[3]), 1);
    tick();
    drive_t3(1);
    #1 check("t3_rdy1", 32'(s_ready[3]), 1);
    tick();
    drive_t3(2);
    #1 check("t3_rdy2", 32'(s_ready[3]), 1);
    check("t3_lat_valid", 32'(m_valid[3]), 0);
    tick();
    drive_t3(3);
    #1;
    check("t3_full_rdy", 32'(s_ready[3]), 0);
    check("t3_full_valid", 32'(m_valid[3]), 1);
    check("t3_full_hit", 32'(m_hit[3]), 32'(t3_hit[0]));
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      check("t3_hold_valid", 32'(m_valid[3]), 1);
      check("t3_hold_hit", 32'(m_hit[3]), 32'(t3_hit[0]));
      check("t3_hold_any", 32'(m_any[3]), 1);
      check("t3_hold_idx", 32'(m_idx[3]), 0);
      check("t3_hold_rdy", 32'(s_ready[3]), 0);
    end
    m_ready[3] = 1'b1;
    snt = 3;
    rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      #1;
      acc_in = s_valid[3] & s_ready[3];
      if (m_valid[3] && m_ready[3]) begin
        check($sformatf("t3_beat%0d_hit", rcv), 32'(m_hit[3]), 32'(t3_hit[rcv]));
        check($sformatf("t3_beat%0d_idx", rcv), 32'(m_idx[3]), 32'(t3_idx[rcv]));
        rcv++;
      end
      tick();
      if (acc_in) snt++;
      if (snt < 6) drive_t3(snt);
      else s_valid[3] = 1'b0;
    end
    check("t3_count", 32'(rcv), 6);
    s_valid[3] = 1'b0;
    tick();
    tick();
    check("t3_no_dup", 32'(m_valid[3]), 0);
    m_ready[3] = 1'b0;

    // Test 4: depth 1, reset pulse while a beat is held and another waits
    m_ready[1] = 1'b0;
    drive(1, 1'b0, 5'h1A, 5'h00, 1'b1);
    #1 check("t4_rdy_empty", 32'(s_ready[1]), 1);
    tick();
    drive(1, 1'b0, 5'h03, 5'h00, 1'b1);
    #1;
    check("t4_valid", 32'(m_valid[1]), 1);
    check("t4_hit", 32'(m_hit[1]), 32'h1);
    check("t4_rdy_full", 32'(s_ready[1]), 0);
    #2 areset = 1'b1;
    #1;
    check("t4_rst_valid", 32'(m_valid[1]), 0);
    check("t4_rst_hit", 32'(m_hit[1]), 0);
    check("t4_rst_any", 32'(m_any[1]), 0);
    check("t4_rst_cnt", 32'(hit_cnt[1]), 0);
    check("t4_rst_rdy", 32'(s_ready[1]), 0);
    tick();
    areset = 1'b0;
    s_valid[1] = 1'b0;
    m_ready[1] = 1'b1;
    #1 check("t4_rel_rdy_low", 32'(s_ready[1]), 0);
    tick();
    check("t4_rel_rdy_high", 32'(s_ready[1]), 1);
    check("t4_no_stale", 32'(m_valid[1]), 0);
    drive(1, 1'b0, 5'h00, 5'h00, 1'b1);
    tick();
    s_valid[1] = 1'b0;
    #1;
    check("t4_new_valid", 32'(m_valid[1]), 1);
    check("t4_new_hit", 32'(m_hit[1]), 0);
    tick();
    check("t4_new_drained", 32'(m_valid[1]), 0);
    m_ready[1] = 1'b0;

    // Test 5: depth 0, combinational follow with M_READY toggling
    for (int i = 0; i < 6; i++) begin
      m_ready[0] = (i == 2 || i == 3);
      drive(0, 1'b0, (i % 2 == 0) ? 5'h1A : 5'h00, 5'h00, 1'b1);
      #1;
      check($sformatf("t5_hit%0d", i), 32'(m_hit[0]), (i % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("t5_valid%0d", i), 32'(m_valid[0]), 1);
      check($sformatf("t5_rdy%0d", i), 32'(s_ready[0]), (i == 2 || i == 3) ? 32'h1 : 32'h0);
      tick();
    end
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b0;
    #1;
`ifdef COMPARATOR_SEL_PIPE_HIT_CNT_EN
    check("t5_hit_cnt", 32'(hit_cnt[0]), 1);
`else
    check("t5_hit_cnt", 32'(hit_cnt[0]), 0);
`endif

    // Test 6: long run of hit beats through depth 0
    m_ready[0] = 1'b1;
    drive(0, 1'b0, 5'h1A, 5'h00, 1'b1);
`ifdef COMPARATOR_SEL_PIPE_HIT_CNT_EN
    repeat (70000) tick();
    check("t6_hit_cnt_sat", 32'(hit_cnt[0]), 32'hFFFF);
    tick();
    check("t6_hit_cnt_hold", 32'(hit_cnt[0]), 32'hFFFF);
`else
    repeat (200) tick();
    check("t6_hit_cnt_off", 32'(hit_cnt[0]), 0);
`endif
    check("t6_hit_cnt_d1", 32'(hit_cnt[1]), 0);
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
